// File: rtl/game_render_pkg.sv
// Shared raster timing defaults, object sizes and colour constants for the
// frame renderer and the game core.
package game_render_pkg;

  // Default 1024x768 raster timing
  localparam int unsigned H_VIS_DEF  = 1024;
  localparam int unsigned H_FP_DEF   = 24;
  localparam int unsigned H_SYNC_DEF = 136;
  localparam int unsigned H_BP_DEF   = 160;
  localparam int unsigned V_VIS_DEF  = 768;
  localparam int unsigned V_FP_DEF   = 3;
  localparam int unsigned V_SYNC_DEF = 6;
  localparam int unsigned V_BP_DEF   = 29;

  // Total period of a line or frame from its four timing segments
  function automatic int unsigned raster_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOT_DEF = raster_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOT_DEF = raster_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Coordinate width and object sizes, shared with the game core
  localparam int unsigned COORD_W_DEF  = 11;
  localparam int unsigned PLAT_W_DEF   = 100;
  localparam int unsigned PLAT_H_DEF   = 30;
  localparam int unsigned DOODLE_W_DEF = 80;
  localparam int unsigned DOODLE_H_DEF = 80;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK   = rgb_t'(12'h000);
  localparam rgb_t C_RED     = rgb_t'(12'hF00);
  localparam rgb_t C_YELLOW  = rgb_t'(12'hFF0);
  localparam rgb_t C_GREEN   = rgb_t'(12'h0F0);
  localparam rgb_t C_SKY     = rgb_t'(12'h8CF);
  localparam rgb_t C_MAGENTA = rgb_t'(12'hF0F);
  localparam rgb_t C_WHITE   = rgb_t'(12'hFFF);

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator: horizontal/vertical counters, raw active-low syncs,
// display enable and the once-per-frame snapshot strobe.
module vga_timing
  import game_render_pkg::*;
#(
  parameter int unsigned H_VIS  = H_VIS_DEF,
  parameter int unsigned H_FP   = H_FP_DEF,
  parameter int unsigned H_SYNC = H_SYNC_DEF,
  parameter int unsigned H_BP   = H_BP_DEF,
  parameter int unsigned V_VIS  = V_VIS_DEF,
  parameter int unsigned V_FP   = V_FP_DEF,
  parameter int unsigned V_SYNC = V_SYNC_DEF,
  parameter int unsigned V_BP   = V_BP_DEF,
  parameter int unsigned CNT_W  = COORD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hs_n_o,
  output logic             vs_n_o,
  output logic             de_o,
  output logic             snap_o
);

  localparam int unsigned H_TOT = raster_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = raster_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_PRE_SNP = CNT_W'(V_VIS - 1);
  localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             snap_q, snap_d;

  // Next raster position; the strobe is decoded on the last pixel before
  // (0, V_VIS) so that, once registered, it is high exactly on that position.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    snap_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_PRE_SNP);
  end

  // Raster counters and snapshot strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      snap_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      snap_q  <= snap_d;
    end
  end

  // Raw timing decoded from the current counter values
  always_comb begin
    h_cnt_o = h_cnt_q;
    v_cnt_o = v_cnt_q;
    hs_n_o  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_n_o  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    de_o    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    snap_o  = snap_q;
  end

endmodule

// File: rtl/game_frame_renderer.sv
// Game frame renderer: snapshots object positions during vertical blanking and
// produces a 2-stage pipelined VGA pixel stream (hit test, then colour mux).
// Optional macro HITBOX_DEBUG_EN: draws the doodle as a magenta outline and
// platform outlines in white instead of solid fills.
module game_frame_renderer
  import game_render_pkg::*;
#(
  parameter int unsigned H_VIS    = H_VIS_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_VIS    = V_VIS_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned PLAT_W   = PLAT_W_DEF,
  parameter int unsigned PLAT_H   = PLAT_H_DEF,
  parameter int unsigned DOODLE_W = DOODLE_W_DEF,
  parameter int unsigned DOODLE_H = DOODLE_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] platform_h_0,
  input  logic [COORD_W-1:0] platform_h_1,
  input  logic [COORD_W-1:0] platform_h_2,
  input  logic [COORD_W-1:0] platform_h_3,
  input  logic [COORD_W-1:0] platform_v_0,
  input  logic [COORD_W-1:0] platform_v_1,
  input  logic [COORD_W-1:0] platform_v_2,
  input  logic [COORD_W-1:0] platform_v_3,
  input  logic [COORD_W-1:0] doodle_h,
  input  logic [COORD_W-1:0] doodle_v,
  input  logic               game_over,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic               frame_start
);

  // One extra bit so right/bottom edges past the raster never wrap
  localparam int unsigned XW = COORD_W + 1;

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               hs_raw, vs_raw, de_raw, snap;

  vga_timing #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP),
    .CNT_W (COORD_W)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt),
    .hs_n_o (hs_raw),
    .vs_n_o (vs_raw),
    .de_o   (de_raw),
    .snap_o (snap)
  );

  // Object rectangle test; objects anchored outside the visible area never hit
  function automatic logic in_box(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                  input logic [XW-1:0] ox, input logic [XW-1:0] oy,
                                  input logic [XW-1:0] ow, input logic [XW-1:0] oh);
    return (ox < XW'(H_VIS)) && (oy < XW'(V_VIS)) &&
           (x >= ox) && (x < ox + ow) && (y >= oy) && (y < oy + oh);
  endfunction

`ifdef HITBOX_DEBUG_EN
  // True on the 1-pixel border of a rectangle already known to contain (x,y)
  function automatic logic on_border(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                     input logic [XW-1:0] ox, input logic [XW-1:0] oy,
                                     input logic [XW-1:0] ow, input logic [XW-1:0] oh);
    return (x == ox) || (x == ox + ow - XW'(1)) || (y == oy) || (y == oy + oh - XW'(1));
  endfunction
`endif

  logic [3:0][COORD_W-1:0] plat_h_in, plat_v_in;
  logic [3:0][COORD_W-1:0] plat_h_q, plat_v_q;
  logic [COORD_W-1:0]      doodle_h_q, doodle_v_q;
  logic                    game_over_q;

  // Gather the platform inputs so they can be handled in loops
  always_comb begin
    plat_h_in = {platform_h_3, platform_h_2, platform_h_1, platform_h_0};
    plat_v_in = {platform_v_3, platform_v_2, platform_v_1, platform_v_0};
  end

  // Shadow registers, loaded only on the snapshot strobe so a frame never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plat_h_q    <= '0;
      plat_v_q    <= '0;
      doodle_h_q  <= '0;
      doodle_v_q  <= '0;
      game_over_q <= 1'b0;
    end else if (snap) begin
      plat_h_q    <= plat_h_in;
      plat_v_q    <= plat_v_in;
      doodle_h_q  <= doodle_h;
      doodle_v_q  <= doodle_v;
      game_over_q <= game_over;
    end
  end

  logic [XW-1:0] px, py;
  logic          plat_hit_d, doodle_hit_d;
`ifdef HITBOX_DEBUG_EN
  logic          plat_edge_d, doodle_edge_d;
`endif

  // Stage 1 hit flags for the current raster position
  always_comb begin
    px         = {1'b0, h_cnt};
    py         = {1'b0, v_cnt};
    plat_hit_d = 1'b0;
`ifdef HITBOX_DEBUG_EN
    plat_edge_d = 1'b0;
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      if (in_box(px, py, {1'b0, plat_h_q[i]}, {1'b0, plat_v_q[i]}, XW'(PLAT_W), XW'(PLAT_H))) begin
        plat_hit_d = 1'b1;
`ifdef HITBOX_DEBUG_EN
        if (on_border(px, py, {1'b0, plat_h_q[i]}, {1'b0, plat_v_q[i]}, XW'(PLAT_W), XW'(PLAT_H)))
          plat_edge_d = 1'b1;
`endif
      end
    end
    doodle_hit_d = in_box(px, py, {1'b0, doodle_h_q}, {1'b0, doodle_v_q},
                          XW'(DOODLE_W), XW'(DOODLE_H));
`ifdef HITBOX_DEBUG_EN
    doodle_edge_d = doodle_hit_d &&
                    on_border(px, py, {1'b0, doodle_h_q}, {1'b0, doodle_v_q},
                              XW'(DOODLE_W), XW'(DOODLE_H));
`endif
  end

  logic hs_s1_q, vs_s1_q, de_s1_q, go_s1_q, plat_s1_q;
`ifdef HITBOX_DEBUG_EN
  logic plat_edge_s1_q, doodle_edge_s1_q;
`else
  logic doodle_s1_q;
`endif

  // Stage 1 registers: hit flags plus matching delay of raw timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_s1_q          <= 1'b1;
      vs_s1_q          <= 1'b1;
      de_s1_q          <= 1'b0;
      go_s1_q          <= 1'b0;
      plat_s1_q        <= 1'b0;
`ifdef HITBOX_DEBUG_EN
      plat_edge_s1_q   <= 1'b0;
      doodle_edge_s1_q <= 1'b0;
`else
      doodle_s1_q      <= 1'b0;
`endif
    end else begin
      hs_s1_q          <= hs_raw;
      vs_s1_q          <= vs_raw;
      de_s1_q          <= de_raw;
      go_s1_q          <= game_over_q;
      plat_s1_q        <= plat_hit_d;
`ifdef HITBOX_DEBUG_EN
      plat_edge_s1_q   <= plat_edge_d;
      doodle_edge_s1_q <= doodle_edge_d;
`else
      doodle_s1_q      <= doodle_hit_d;
`endif
    end
  end

  rgb_t rgb_d, rgb_q;
  logic hs_q, vs_q, de_q;

  // Stage 2 priority colour select
  always_comb begin
    rgb_d = C_BLACK;
    if (!de_s1_q)             rgb_d = C_BLACK;
    else if (go_s1_q)         rgb_d = C_RED;
`ifdef HITBOX_DEBUG_EN
    else if (doodle_edge_s1_q) rgb_d = C_MAGENTA;
    else if (plat_edge_s1_q)   rgb_d = C_WHITE;
`else
    else if (doodle_s1_q)     rgb_d = C_YELLOW;
`endif
    else if (plat_s1_q)       rgb_d = C_GREEN;
    else                      rgb_d = C_SKY;
  end

  // Stage 2 registers driving the DAC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= C_BLACK;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_s1_q;
      vs_q  <= vs_s1_q;
      de_q  <= de_s1_q;
    end
  end

  // Output mapping
  always_comb begin
    vga_r       = rgb_q.r;
    vga_g       = rgb_q.g;
    vga_b       = rgb_q.b;
    vga_hs      = hs_q;
    vga_vs      = vs_q;
    vga_de      = de_q;
    frame_start = snap;
  end

endmodule

// File: doc/game_frame_renderer.md
Name: game_frame_renderer

Overview:
- Reads the game core's position outputs (four platforms, doodle, game_over) and produces the VGA pixel stream.
- Contains its own raster timing generator and snapshots all positions once per frame, during vertical blanking, so a frame never tears.
- Sits between the game core and the board VGA DAC; its frame_start pulse can pace the game core.

Parameters:
- H_VIS, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_VIS, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- COORD_W, 11, coordinate input width; 9-bit game outputs are zero-extended
- PLAT_W, 100, platform width in pixels
- PLAT_H, 30, platform height in pixels
- DOODLE_W, 80, doodle width in pixels
- DOODLE_H, 80, doodle height in pixels

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- platform_h_0..3  in  COORD_W  platform left edge x
- platform_v_0..3  in  COORD_W  platform top edge y
- doodle_h  in  COORD_W  doodle left edge x
- doodle_v  in  COORD_W  doodle top edge y
- game_over  in  1  game-over flag
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_de  out  1  display enable
- frame_start  out  1  one-cycle pulse when the snapshot is taken

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- On reset:
  - h_cnt=0, v_cnt=0.
  - All shadow registers = 0.
  - RGB=0, vga_de=0, frame_start=0.
  - vga_hs=1 and vga_vs=1 (inactive).
- Reset asserted mid-line aborts the frame immediately. After release, the raster restarts at (0,0) on the first clk edge.
- h_cnt counts 0..H_TOT-1, where H_TOT = sum of the H_* parameters (1344 at defaults), then wraps to 0.
- v_cnt increments when h_cnt wraps, over 0..V_TOT-1 (806 at defaults), then wraps to 0.
- Raw timing, before pipeline delay:
  - hs_n = 0 when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC.
  - vs_n is the same rule on v_cnt with the V_* parameters.
  - de = (h_cnt < H_VIS) && (v_cnt < V_VIS).
- Snapshot:
  - Taken on the cycle with h_cnt==0 and v_cnt==V_VIS.
  - All 8 platform coordinates, doodle_h, doodle_v and game_over are copied into shadow registers.
  - frame_start is high for exactly that cycle.
  - Input changes at any other time have no effect until the next snapshot.
- Pipeline stage 1 (registered): hit flags computed from h_cnt, v_cnt and the shadow registers.
  - Platform hit (each platform separately): px <= x < px+PLAT_W and py <= y < py+PLAT_H.
  - Doodle hit: the same rule with DOODLE_W and DOODLE_H.
  - All sums are computed in COORD_W+1 bits, so a right or bottom edge past the raster does not wrap.
  - Any object with top y >= V_VIS or left x >= H_VIS is never drawn.
- Pipeline stage 2 (registered): priority colour select, highest first.
  - !de: black.
  - game_over: red 0xF00 fills the entire visible area.
  - doodle: yellow 0xFF0.
  - any platform: green 0x0F0.
  - background: light blue 0x8CF.
- Latency: pixel (x,y) appears 2 cycles after h_cnt==x, v_cnt==y. hs_n, vs_n and de pass through a matching 2-stage delay.
- Platforms that overlap each other: same green, no error.

Optional Feature:
- Macro: HITBOX_DEBUG_EN.
- When defined:
  - The doodle is drawn as a 1-pixel magenta (0xF0F) outline of its rectangle only. The interior shows whatever lies beneath it.
  - Platform outlines are drawn white (0xFFF).
  - Priority otherwise unchanged.
- When undefined: solid fills exactly as in Behaviour. No extra logic is generated.

Decomposition:
- Shared package game_render_pkg holds:
  - default timing constants and the H_TOT/V_TOT derivation;
  - object sizes, shared with the game core;
  - 12-bit colour constants;
  - an rgb_t typedef.
- One sub-module is natural: vga_timing. It owns h_cnt/v_cnt, raw sync/de and the snapshot-strobe generation.
- Hit testing and the colour mux stay in the top module.

Test Plan:
- Reset, then free-run: vga_hs low for exactly 136 cycles per 1344-cycle line; vga_vs low for exactly 6 lines per 806-line frame; vga_de high for 1024x768 pixels per frame.
- Assert reset at h_cnt=500, v_cnt=300 for 3 cycles: outputs take reset values immediately; first pixel after release is (0,0), visible 2 cycles later.
- platform_0 = (400,525), other objects off-screen: pixels (400,525) and (499,554) green; (399,525), (500,525) and (400,555) background.
- Change doodle_v from 600 to 300 mid-frame at line 200: doodle stays at row 600 for the current frame; moves to row 300 only after the next frame_start.
- Doodle (420,520) overlaps platform_0 (400,525): pixel (430,530) yellow; with game_over=1 at the snapshot, every visible pixel red.
- platform_v_3 = 1000: never drawn. platform_h_1 = 1000: drawn for x = 1000..1023 only, with no wrap to x = 0..75.
